// File: rtl/flash_boot_if.sv
`timescale 1ns/1ps
// flash_boot_if: groups the boot copier's control, SPI and SRAM signals.
//
//   start      request to begin a boot copy (one-cycle pulse)
//   spi_in     command to the SPI byte controller: [7:0] byte, [8]=1 deselect
//   spi_load   one-cycle strobe latching spi_in into the SPI controller
//   spi_out    SPI controller status: [15]=busy, [7:0] last received byte
//   sram_addr  SRAM word address of the current write
//   sram_din   SRAM write data
//   sram_load  one-cycle SRAM write strobe
//   busy       copy in progress
//   done       one-cycle pulse when the copy is complete
//
// master: the copier itself.  slave: the surrounding system.
interface flash_boot_if;
    logic        start;
    logic [15:0] spi_in;
    logic        spi_load;
    logic [15:0] spi_out;
    logic [15:0] sram_addr;
    logic [15:0] sram_din;
    logic        sram_load;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        input  spi_out,
        output spi_in,
        output spi_load,
        output sram_addr,
        output sram_din,
        output sram_load,
        output busy,
        output done
    );

    modport slave (
        output start,
        output spi_out,
        input  spi_in,
        input  spi_load,
        input  sram_addr,
        input  sram_din,
        input  sram_load,
        input  busy,
        input  done
    );
endinterface

// File: rtl/flash_boot.sv
`timescale 1ns/1ps
// flash_boot: copies N_WORDS big-endian 16-bit words from SPI flash, starting
// at byte address FLASH_BASE, into SRAM words 0..N_WORDS-1, then deselects
// the flash and pulses done (used to reset the PC and execute from SRAM).
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous active-high reset; abandons any copy in progress
//   bus    flash_boot_if.master: start in, SPI command/strobe out, SPI status
//          in, SRAM address/data/strobe out, busy/done out
//
// All outputs are registered. Every SPI byte takes an issue cycle (strobe),
// a guard cycle (controller busy flag not yet valid, so ignored), and then
// waits for the busy flag to drop.
module flash_boot #(
    parameter logic [23:0] FLASH_BASE = 24'h010000,
    parameter logic [15:0] N_WORDS    = 16'd256
) (
    input  logic         clk,
    input  logic         reset,
    flash_boot_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, CMD, A2, A1, A0, RDHI, RDLO, WR, DESEL, FIN
    } state_t;

    typedef enum logic [1:0] {PH_ISSUE, PH_GUARD, PH_WAIT} phase_t;

    localparam logic [15:0] LAST_WORD = N_WORDS - 16'd1;

    state_t      state_q, state_d, nxt_state;
    phase_t      phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] spi_in_q, spi_in_d;
    logic        spi_load_q, spi_load_d;
    logic [15:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_din_q, sram_din_d;
    logic        sram_load_q, sram_load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Status bits other than busy and the received byte carry no meaning here.
    logic unused_status;
    assign unused_status = ^bus.spi_out[14:8];

    // Word sent to the SPI controller on entry to a byte state.
    function automatic logic [15:0] issue_word(state_t s);
        case (s)
            CMD:     return 16'h0003;
            A2:      return {8'h00, FLASH_BASE[23:16]};
            A1:      return {8'h00, FLASH_BASE[15:8]};
            A0:      return {8'h00, FLASH_BASE[7:0]};
            DESEL:   return 16'h0100;
            default: return 16'h0000;
        endcase
    endfunction

    // Successor of a byte state once its SPI transfer has completed.
    function automatic state_t after_byte(state_t s);
        case (s)
            CMD:     return A2;
            A2:      return A1;
            A1:      return A0;
            A0:      return RDHI;
            RDHI:    return RDLO;
            RDLO:    return WR;
            default: return FIN;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        spi_in_d    = spi_in_q;
        sram_addr_d = sram_addr_q;
        sram_din_d  = sram_din_q;
        busy_d      = busy_q;
        spi_load_d  = 1'b0;
        sram_load_d = 1'b0;
        done_d      = 1'b0;
        nxt_state   = after_byte(state_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = CMD;
                    phase_d    = PH_ISSUE;
                    cnt_d      = 16'h0000;
                    busy_d     = 1'b1;
                    spi_in_d   = issue_word(CMD);
                    spi_load_d = 1'b1;
                end
            end
            CMD, A2, A1, A0, RDHI, RDLO, DESEL: begin
                case (phase_q)
                    PH_ISSUE: phase_d = PH_GUARD;
                    PH_GUARD: phase_d = PH_WAIT;
                    default: begin
                        if (!bus.spi_out[15]) begin
                            state_d = nxt_state;
                            phase_d = PH_ISSUE;
                            if (state_q == RDHI) begin
                                hi_d = bus.spi_out[7:0];
                            end
                            if (state_q == RDLO) begin
                                lo_d = bus.spi_out[7:0];
                            end
                            // The strobe for the next state is prepared here so
                            // that it is registered on entry to that state.
                            if (nxt_state == WR) begin
                                sram_load_d = 1'b1;
                                sram_addr_d = cnt_q;
                                sram_din_d  = {hi_q, lo_d};
                            end else if (nxt_state == FIN) begin
                                done_d = 1'b1;
                            end else begin
                                spi_load_d = 1'b1;
                                spi_in_d   = issue_word(nxt_state);
                            end
                        end
                    end
                endcase
            end
            WR: begin
                // Flash keeps streaming sequential bytes, so further words need
                // only dummy reads, no new command or address.
                cnt_d      = cnt_q + 16'd1;
                phase_d    = PH_ISSUE;
                state_d    = (cnt_q == LAST_WORD) ? DESEL : RDHI;
                spi_load_d = 1'b1;
                spi_in_d   = issue_word(state_d);
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= PH_ISSUE;
            cnt_q       <= 16'h0000;
            hi_q        <= 8'h00;
            lo_q        <= 8'h00;
            spi_in_q    <= 16'h0000;
            spi_load_q  <= 1'b0;
            sram_addr_q <= 16'h0000;
            sram_din_q  <= 16'h0000;
            sram_load_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            spi_in_q    <= spi_in_d;
            spi_load_q  <= spi_load_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
            sram_load_q <= sram_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.spi_in    = spi_in_q;
    assign bus.spi_load  = spi_load_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_din  = sram_din_q;
    assign bus.sram_load = sram_load_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
